// File: rtl/window_buffer_5x5_ctrl_pkg.sv
// Shared definitions for the 5x5 window buffer sequencing controller.
// Holds the controller state encoding, the window geometry (WIN, HALF) and
// the default position-counter width.
package window_buffer_5x5_ctrl_pkg;

    localparam int CW_DEFAULT = 10;  // counter width; holds max(COLS, ROWS)
    localparam int WIN        = 5;   // window edge length in pixels
    localparam int HALF       = 2;   // offset from window edge to its centre

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_ROW = 3'd1,
        ROW      = 3'd2,
        DRAIN    = 3'd3,
        DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/window_buffer_5x5_ctrl_wb_valid_delay.sv
// wb_valid_delay: LAT-deep shift register carrying {valid, col, row}.
// Re-times a window-valid strobe and its centre coordinates so they line up
// with the datapath outputs. Coordinates in each stage only load when the
// valid entering that stage is set, so the outputs hold the last valid
// coordinates while vld_o is low.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears all stages)
//   iv_i          window-valid strobe entering the pipe
//   col_i, row_i  centre coordinates accompanying iv_i
//   vld_o         iv_i delayed by LAT cycles
//   col_o, row_o  coordinates of the most recent valid that left the pipe
module wb_valid_delay #(
    parameter int LAT = 2,
    parameter int CW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iv_i,
    input  logic [CW-1:0] col_i,
    input  logic [CW-1:0] row_i,
    output logic          vld_o,
    output logic [CW-1:0] col_o,
    output logic [CW-1:0] row_o
);

    logic [LAT-1:0] vld_q, vld_d;
    logic [CW-1:0]  col_q [LAT];
    logic [CW-1:0]  col_d [LAT];
    logic [CW-1:0]  row_q [LAT];
    logic [CW-1:0]  row_d [LAT];

    always_comb begin
        vld_d[0] = iv_i;
        col_d[0] = iv_i ? col_i : col_q[0];
        row_d[0] = iv_i ? row_i : row_q[0];
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            col_d[i] = vld_q[i-1] ? col_q[i-1] : col_q[i];
            row_d[i] = vld_q[i-1] ? row_q[i-1] : row_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                col_q[i] <= '0;
                row_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                col_q[i] <= col_d[i];
                row_q[i] <= row_d[i];
            end
        end
    end

    assign vld_o = vld_q[LAT-1];
    assign col_o = col_q[LAT-1];
    assign row_o = row_q[LAT-1];

endmodule

// File: rtl/window_buffer_5x5_ctrl.sv
// window_buffer_5x5_ctrl: sequencing controller for the 5x5 window buffer.
// Counts columns and row-groups from the line buffer's column-valid strobe,
// flags each complete 5x5 window, and re-times that flag and its centre
// coordinates by LAT cycles to match the datapath outputs. Also reports
// frame busy/done and a sticky in-row column-gap error.
//
// Optional feature: define WB5_CTRL_GAP_CHECK_EN to detect column gaps inside
// a row (sets err_o, restarts window fill). Without it err_o is tied low and
// upstream must deliver each row's columns contiguously.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         one-cycle pulse, arms a frame (ignored while busy)
//   col_valid_i     a 5-tap column is presented to the datapath this cycle
//   win_valid_o     datapath outputs hold a complete 5x5 window
//   win_col_o       centre column of the current window
//   win_row_o       centre row of the current window
//   busy_o          frame in progress
//   done_o          one-cycle pulse after the last window of the frame
//   err_o           sticky column-gap error (cleared by rst or start)
module window_buffer_5x5_ctrl
    import window_buffer_5x5_ctrl_pkg::*;
#(
    parameter int COLS = 640,
    parameter int ROWS = 480,
    parameter int CW   = CW_DEFAULT,
    parameter int LAT  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          col_valid_i,
    output logic          win_valid_o,
    output logic [CW-1:0] win_col_o,
    output logic [CW-1:0] win_row_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [CW-1:0] ROW_LAST   = CW'(ROWS - WIN);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(LAT - 1);
    localparam logic [2:0]    FILL_FULL  = 3'(WIN - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d;
    logic [2:0]    fill_cnt_q, fill_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          iv;
    logic [CW-1:0] iv_col;
    logic [CW-1:0] iv_row;

    always_comb begin
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        row_cnt_d   = row_cnt_q;
        drain_cnt_d = drain_cnt_q;
        fill_cnt_d  = fill_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        iv          = 1'b0;
        // The accepted column is the right edge of the window, so its centre
        // sits HALF columns back; row_cnt indexes the window's top line.
        iv_col      = col_cnt_q - CW'(HALF);
        iv_row      = row_cnt_q + CW'(HALF);

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = WAIT_ROW;
                    busy_d     = 1'b1;
                    col_cnt_d  = '0;
                    row_cnt_d  = '0;
                    fill_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            WAIT_ROW: begin
                // First column of a row: fill restarts at 0 and counts it.
                if (col_valid_i) begin
                    state_d    = ROW;
                    col_cnt_d  = CW'(1);
                    fill_cnt_d = 3'd1;
                end
            end
            ROW: begin
                if (col_valid_i) begin
                    // Fill saturates; every column beyond the 4th contiguous
                    // one completes a window.
                    if (fill_cnt_q == FILL_FULL) begin
                        iv = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 3'd1;
                    end
                    if (col_cnt_q == COL_LAST) begin
                        col_cnt_d = '0;
                        if (row_cnt_q == ROW_LAST) begin
                            state_d     = DRAIN;
                            drain_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + CW'(1);
                            state_d   = WAIT_ROW;
                        end
                    end else begin
                        col_cnt_d = col_cnt_q + CW'(1);
                    end
                end
`ifdef WB5_CTRL_GAP_CHECK_EN
                else if (col_cnt_q != '0) begin
                    // Windows spanning the gap are invalid; column position
                    // is kept so counting resumes on the next valid column.
                    err_d      = 1'b1;
                    fill_cnt_d = '0;
                end
`endif
            end
            DRAIN: begin
                // Wait for the last window to emerge from the delay pipe.
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            row_cnt_q   <= '0;
            drain_cnt_q <= '0;
            fill_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            row_cnt_q   <= row_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            fill_cnt_q  <= fill_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    wb_valid_delay #(
        .LAT (LAT),
        .CW  (CW)
    ) u_valid_delay (
        .clk   (clk),
        .rst   (rst),
        .iv_i  (iv),
        .col_i (iv_col),
        .row_i (iv_row),
        .vld_o (win_valid_o),
        .col_o (win_col_o),
        .row_o (win_row_o)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;
`ifdef WB5_CTRL_GAP_CHECK_EN
    assign err_o  = err_q;
`else
    assign err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_window_buffer_5x5_ctrl.sv
`timescale 1ns/1ps
module tb_window_buffer_5x5_ctrl;

    localparam int COLS = 8;
    localparam int ROWS = 7;
    localparam int CW   = 10;
    localparam int LAT  = 2;
    localparam int NWIN = (COLS - 4) * (ROWS - 4);
`ifdef WB5_CTRL_GAP_CHECK_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          col_valid_i;
    logic          win_valid_o;
    logic [CW-1:0] win_col_o;
    logic [CW-1:0] win_row_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    always #5 clk = ~clk;

    window_buffer_5x5_ctrl #(
        .COLS (COLS),
        .ROWS (ROWS),
        .CW   (CW),
        .LAT  (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .col_valid_i (col_valid_i),
        .win_valid_o (win_valid_o),
        .win_col_o   (win_col_o),
        .win_row_o   (win_row_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed { logic rv; logic st; logic cv; } stim_t;
    typedef struct { int at; int col; int row; } win_t;

    stim_t sq[$];
    win_t  wq[$];
    int    seen_col[$];
    int    seen_row[$];
    int    exp_col[$];
    int    exp_row[$];

    // Reference model: frame-level view built from integer counts.
    bit m_busy, m_err, m_recv;
    int m_col, m_row, m_run, m_done_at = -1, m_hold_col, m_hold_row;

    int              r_mism, r_done, r_at;
    logic [2*CW+3:0] r_obs, r_exp;

    function automatic void add_stim(bit rv, bit st, bit cv, int n = 1);
        for (int i = 0; i < n; i++) sq.push_back('{rv, st, cv});
    endfunction

    function automatic void build_frame(int gap_row, int gap_col, bit noisy, bit tail_cv);
        add_stim(0, 1, 0);
        for (int r = 0; r < ROWS - 4; r++) begin
            add_stim(0, noisy, 0, 2 + int'($urandom_range(0, 2)));
            for (int c = 0; c < COLS; c++) begin
                if (r == gap_row && c == gap_col) add_stim(0, 0, 0);
                add_stim(0, noisy && ($urandom_range(0, 2) == 0), 1);
            end
        end
        add_stim(0, 0, tail_cv, LAT + 2);
        add_stim(0, 0, 0, 3);
    endfunction

    function automatic void clean_list();
        exp_col.delete();
        exp_row.delete();
        for (int r = 0; r < ROWS - 4; r++)
            for (int c = 0; c < COLS - 4; c++) begin
                exp_col.push_back(c + 2);
                exp_row.push_back(r + 2);
            end
    endfunction

    task automatic model_edge(input stim_t s);
        if (s.rv) begin
            m_busy = 0; m_err = 0; m_recv = 0;
            m_col = 0; m_row = 0; m_run = 0; m_done_at = -1;
            m_hold_col = 0; m_hold_row = 0;
            wq.delete();
            return;
        end
        if (!m_busy && s.st) begin
            m_busy = 1; m_recv = 1; m_err = 0;
            m_col = 0; m_row = 0; m_run = 0;
        end else if (m_recv && s.cv) begin
            // A window exists once the last five accepted columns of this
            // row are contiguous; its centre is two columns back.
            m_run++;
            if (m_run >= 5) wq.push_back('{cyc + LAT - 1, m_col - 2, m_row + 2});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_run = 0;
                if (m_row == ROWS - 5) begin
                    m_recv = 0;
                    m_done_at = cyc + LAT;
                end else begin
                    m_row++;
                end
            end
        end else if (m_recv && !s.cv && m_col > 0 && GAP_EN) begin
            m_err = 1;
            m_run = 0;
        end
        if (cyc == m_done_at) m_busy = 0;
    endtask

    task automatic play();
        logic [2*CW+3:0] obs, expv;
        bit ev;
        r_mism = 0; r_done = 0; r_at = 0; r_obs = '0; r_exp = '0;
        seen_col.delete();
        seen_row.delete();
        foreach (sq[i]) begin
            rst = sq[i].rv; start_i = sq[i].st; col_valid_i = sq[i].cv;
            @(posedge clk);
            cyc++;
            model_edge(sq[i]);
            #1;
            ev = 0;
            if (wq.size() > 0 && wq[0].at == cyc) begin
                ev = 1;
                m_hold_col = wq[0].col;
                m_hold_row = wq[0].row;
                wq.delete(0);
            end
            expv = {ev, CW'(m_hold_col), CW'(m_hold_row), m_busy, (cyc == m_done_at), m_err};
            obs  = {win_valid_o, win_col_o, win_row_o, busy_o, done_o, err_o};
            if (obs !== expv) begin
                if (r_mism == 0) begin r_obs = obs; r_exp = expv; r_at = cyc; end
                r_mism++;
            end
            if (win_valid_o === 1'b1) begin
                seen_col.push_back(int'(win_col_o));
                seen_row.push_back(int'(win_row_o));
            end
            if (done_o === 1'b1) r_done++;
        end
        sq.delete();
        rst = 0; start_i = 0; col_valid_i = 0;
    endtask

    task automatic test_reset();
        add_stim(1, 0, 0, 3);
        play();
        total++;
        if ({win_valid_o, win_col_o, win_row_o, busy_o, done_o, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got=%h want=0",
                     {win_valid_o, win_col_o, win_row_o, busy_o, done_o, err_o});
        end
        total++;
        if (r_mism !== 0) begin
            bad++;
            $display("FAIL reset_trace: cyc=%0d got=%h want=%h", r_at, r_obs, r_exp);
        end
    endtask

    task automatic test_idle_toggle();
        for (int i = 0; i < 12; i++) add_stim(0, 0, 1'($urandom_range(0, 1)));
        play();
        total++;
        if (r_mism !== 0) begin
            bad++;
            $display("FAIL idle_trace: cyc=%0d got=%h want=%h", r_at, r_obs, r_exp);
        end
        total++;
        if (seen_col.size() !== 0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet: windows=%0d busy=%b want windows=0 busy=0",
                     seen_col.size(), busy_o);
        end
    endtask

    task automatic test_clean_frame();
        build_frame(-1, -1, 0, 0);
        play();
        clean_list();
        total++;
        if (r_mism !== 0) begin
            bad++;
            $display("FAIL clean_trace: cyc=%0d got=%h want=%h", r_at, r_obs, r_exp);
        end
        total++;
        if (seen_col.size() !== NWIN || r_done !== 1 || err_o !== 1'b0) begin
            bad++;
            $display("FAIL clean_counts: windows=%0d done=%0d err=%b want %0d 1 0",
                     seen_col.size(), r_done, err_o, NWIN);
        end
        for (int i = 0; i < exp_col.size() && i < seen_col.size(); i++) begin
            total++;
            if (seen_col[i] !== exp_col[i] || seen_row[i] !== exp_row[i]) begin
                bad++;
                $display("FAIL clean_coord[%0d]: got=(%0d,%0d) want=(%0d,%0d)",
                         i, seen_col[i], seen_row[i], exp_col[i], exp_row[i]);
            end
        end
    endtask

    task automatic test_gap();
        build_frame(0, 5, 0, 0);
        play();
        if (GAP_EN) begin
            clean_list();
            for (int i = 0; i < 3; i++) begin exp_col.delete(1); exp_row.delete(1); end
        end else begin
            clean_list();
        end
        total++;
        if (r_mism !== 0) begin
            bad++;
            $display("FAIL gap_trace: cyc=%0d got=%h want=%h", r_at, r_obs, r_exp);
        end
        total++;
        if (seen_col.size() !== exp_col.size() || r_done !== 1 || err_o !== GAP_EN) begin
            bad++;
            $display("FAIL gap_counts: windows=%0d done=%0d err=%b want %0d 1 %b",
                     seen_col.size(), r_done, err_o, exp_col.size(), GAP_EN);
        end
        for (int i = 0; i < exp_col.size() && i < seen_col.size(); i++) begin
            total++;
            if (seen_col[i] !== exp_col[i] || seen_row[i] !== exp_row[i]) begin
                bad++;
                $display("FAIL gap_coord[%0d]: got=(%0d,%0d) want=(%0d,%0d)",
                         i, seen_col[i], seen_row[i], exp_col[i], exp_row[i]);
            end
        end
        // Random gap placement; a following clean frame must clear err_o.
        build_frame(int'($urandom_range(0, 2)), int'($urandom_range(1, COLS - 1)), 0, 0);
        build_frame(-1, -1, 0, 0);
        play();
        total++;
        if (r_mism !== 0 || err_o !== 1'b0 || r_done !== 2) begin
            bad++;
            $display("FAIL gap_random: mism=%0d err=%b done=%0d cyc=%0d got=%h want=%h",
                     r_mism, err_o, r_done, r_at, r_obs, r_exp);
        end
    endtask

    task automatic test_reset_mid();
        add_stim(0, 1, 0);
        add_stim(0, 0, 0, 2);
        add_stim(0, 0, 1, COLS);
        add_stim(0, 0, 0, 2);
        add_stim(0, 0, 1, 3);
        add_stim(1, 1, 1);
        play();
        total++;
        if ({win_valid_o, win_col_o, win_row_o, busy_o, done_o, err_o} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs: got=%h want=0",
                     {win_valid_o, win_col_o, win_row_o, busy_o, done_o, err_o});
        end
        add_stim(0, 0, 1, 2);
        build_frame(-1, -1, 0, 0);
        play();
        total++;
        if (r_mism !== 0 || seen_col.size() !== NWIN || r_done !== 1) begin
            bad++;
            $display("FAIL reset_mid_frame: mism=%0d windows=%0d done=%0d want 0 %0d 1",
                     r_mism, seen_col.size(), r_done, NWIN);
        end
    endtask

    task automatic test_busy_start();
        build_frame(-1, -1, 1, 0);
        play();
        total++;
        if (r_mism !== 0) begin
            bad++;
            $display("FAIL busy_start_trace: cyc=%0d got=%h want=%h", r_at, r_obs, r_exp);
        end
        total++;
        if (seen_col.size() !== NWIN || r_done !== 1) begin
            bad++;
            $display("FAIL busy_start_counts: windows=%0d done=%0d want %0d 1",
                     seen_col.size(), r_done, NWIN);
        end
    endtask

    task automatic test_back_to_back();
        build_frame(-1, -1, 1, 1);
        build_frame(-1, -1, 1, 1);
        play();
        total++;
        if (r_mism !== 0) begin
            bad++;
            $display("FAIL b2b_trace: cyc=%0d got=%h want=%h", r_at, r_obs, r_exp);
        end
        total++;
        if (seen_col.size() !== 2 * NWIN || r_done !== 2) begin
            bad++;
            $display("FAIL b2b_counts: windows=%0d done=%0d want %0d 2",
                     seen_col.size(), r_done, 2 * NWIN);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        col_valid_i = 1'b0;
        test_reset();
        test_idle_toggle();
        test_clean_frame();
        test_gap();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
